scfifo_param_withcount: RTL and testbench

Parametrised single-clock FIFO with full-range occupancy count, programmable almost-full/almost-empty flags and selectable read mode (standard registered read or first-word-fall-through). It is the successor to the fixed 40x64 counted FIFO. It serves as the generic command/data buffer between NAND channel controllers and upstream dispatch logic. The count is DEPTH-exact, with no truncation at full.

---
 rtl/scfifo_pkg.sv | 30 +++
 rtl/scfifo_ctrl.sv | 82 ++++++++
 rtl/scfifo_param_withcount.sv | 126 ++++++++++++
 tb/tb_scfifo_param_withcount.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/scfifo_pkg.sv
// scfifo_pkg: shared sizing helpers and parameter-legality helpers for the
// parametrised single-clock counted FIFO.
package scfifo_pkg;

    // Occupancy counter width: must represent 0..DEPTH inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 32'sd1;
    endfunction

    // Read/write pointer width: indexes 0..DEPTH-1 and wraps naturally.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // DEPTH must be a power of two and at least 4.
    function automatic bit depth_ok(input int depth);
        return (depth >= 32'sd4) && ((depth & (depth - 32'sd1)) == 32'sd0);
    endfunction

    // Almost-full threshold must lie in 1..DEPTH.
    function automatic bit af_level_ok(input int af_level, input int depth);
        return (af_level >= 32'sd1) && (af_level <= depth);
    endfunction

    // Almost-empty threshold must lie in 0..DEPTH-1.
    function automatic bit ae_level_ok(input int ae_level, input int depth);
        return (ae_level >= 32'sd0) && (ae_level <= (depth - 32'sd1));
    endfunction

endpackage

// File: rtl/scfifo_ctrl.sv
// scfifo_ctrl: pointers, occupancy count, status flags and accept logic.
// All flags are registered from the next-count value so they line up with
// the count register in the same cycle.
module scfifo_ctrl
    import scfifo_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int AF_LEVEL = 60,
    parameter int AE_LEVEL = 4,
    parameter int PW       = ptr_width(DEPTH),
    parameter int CW       = count_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_en_s,
    input  logic          pop_en_s,
    output logic          push_acc_s,
    output logic          pop_acc_s,
    output logic [PW-1:0] wr_ptr_r,
    output logic [PW-1:0] rd_ptr_r,
    output logic [PW-1:0] rd_ptr_next_s,
    output logic [CW-1:0] count_r,
    output logic [CW-1:0] count_next_s,
    output logic          is_full_r,
    output logic          is_empty_r,
    output logic          almost_full_r,
    output logic          almost_empty_r
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [PW-1:0] wr_ptr_next_s;

    // Accept rules use the registered (pre-edge) full/empty flags.
    always_comb begin
        push_acc_s = push_en_s & ~is_full_r;
        pop_acc_s  = pop_en_s & ~is_empty_r;
    end

    // Next pointer and next count; count moves only on a lone push or pop.
    always_comb begin
        if (push_acc_s) begin
            wr_ptr_next_s = wr_ptr_r + PW'(1'b1);
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end
        if (pop_acc_s) begin
            rd_ptr_next_s = rd_ptr_r + PW'(1'b1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        case ({push_acc_s, pop_acc_s})
            2'b10:   count_next_s = count_r + CW'(1'b1);
            2'b01:   count_next_s = count_r - CW'(1'b1);
            default: count_next_s = count_r;
        endcase
    end

    // State and flag registers; reset discards all contents at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r       <= {PW{1'b0}};
            rd_ptr_r       <= {PW{1'b0}};
            count_r        <= {CW{1'b0}};
            is_full_r      <= 1'b0;
            is_empty_r     <= 1'b1;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
        end else begin
            wr_ptr_r       <= wr_ptr_next_s;
            rd_ptr_r       <= rd_ptr_next_s;
            count_r        <= count_next_s;
            is_full_r      <= (count_next_s == DEPTH_C);
            is_empty_r     <= (count_next_s == {CW{1'b0}});
            almost_full_r  <= (count_next_s >= AF_C);
            almost_empty_r <= (count_next_s <= AE_C);
        end
    end

endmodule

// File: rtl/scfifo_param_withcount.sv
// scfifo_param_withcount: parametrised single-clock FIFO with exact 0..DEPTH
// occupancy count, almost-full/almost-empty flags and a selectable read
// stage (FWFT=0 registered read, FWFT=1 first-word-fall-through).
// Optional build macro SCFIFO_ERR_FLAGS_EN enables sticky overflow and
// underflow detection; without it both flags are tied low.
module scfifo_param_withcount
    import scfifo_pkg::*;
#(
    parameter int DATA_WIDTH = 40,
    parameter int DEPTH      = 64,
    parameter int AF_LEVEL   = 60,
    parameter int AE_LEVEL   = 4,
    parameter int FWFT       = 0
) (
    input  logic                          iClock,
    input  logic                          iReset,
    input  logic [DATA_WIDTH-1:0]         iPushData,
    input  logic                          iPushEnable,
    output logic                          oIsFull,
    output logic                          oAlmostFull,
    output logic [DATA_WIDTH-1:0]         oPopData,
    input  logic                          iPopEnable,
    output logic                          oIsEmpty,
    output logic                          oAlmostEmpty,
    output logic [count_width(DEPTH)-1:0] oDataCount,
    output logic                          oOverflow,
    output logic                          oUnderflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic                  push_acc_s;
    logic                  pop_acc_s;
    logic [PW-1:0]         wr_ptr_s;
    logic [PW-1:0]         rd_ptr_s;
    logic [PW-1:0]         rd_ptr_next_s;
    logic [CW-1:0]         count_next_s;
    logic [PW-1:0]         rd_addr_s;
    logic                  load_s;
    logic                  bypass_s;
    logic [DATA_WIDTH-1:0] pop_data_r;
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    scfifo_ctrl #(
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL),
        .PW       (PW),
        .CW       (CW)
    ) u_ctrl (
        .clk            (iClock),
        .rst            (iReset),
        .push_en_s      (iPushEnable),
        .pop_en_s       (iPopEnable),
        .push_acc_s     (push_acc_s),
        .pop_acc_s      (pop_acc_s),
        .wr_ptr_r       (wr_ptr_s),
        .rd_ptr_r       (rd_ptr_s),
        .rd_ptr_next_s  (rd_ptr_next_s),
        .count_r        (oDataCount),
        .count_next_s   (count_next_s),
        .is_full_r      (oIsFull),
        .is_empty_r     (oIsEmpty),
        .almost_full_r  (oAlmostFull),
        .almost_empty_r (oAlmostEmpty)
    );

    // Storage array write port; no reset so it maps onto distributed RAM.
    always_ff @(posedge iClock) begin
        if (push_acc_s) begin
            mem_r[wr_ptr_s] <= iPushData;
        end
    end

    // Output-stage control: FWFT prefetches the post-edge head word (taking
    // the incoming push directly when it lands in the head slot); standard
    // mode reads the current head only on an accepted pop.
    always_comb begin
        if (FWFT != 32'sd0) begin
            rd_addr_s = rd_ptr_next_s;
            load_s    = (count_next_s != {CW{1'b0}});
            bypass_s  = push_acc_s & (rd_ptr_next_s == wr_ptr_s);
        end else begin
            rd_addr_s = rd_ptr_s;
            load_s    = pop_acc_s;
            bypass_s  = 1'b0;
        end
    end

    // Read data register; holds its value whenever nothing new is loaded.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            pop_data_r <= {DATA_WIDTH{1'b0}};
        end else if (load_s) begin
            pop_data_r <= bypass_s ? iPushData : mem_r[rd_addr_s];
        end else begin
            pop_data_r <= pop_data_r;
        end
    end

    assign oPopData = pop_data_r;

`ifdef SCFIFO_ERR_FLAGS_EN
    logic overflow_r;
    logic underflow_r;

    // Sticky error capture: requests made against a full/empty FIFO.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= overflow_r | (iPushEnable & oIsFull);
            underflow_r <= underflow_r | (iPopEnable & oIsEmpty);
        end
    end

    assign oOverflow  = overflow_r;
    assign oUnderflow = underflow_r;
`else
    assign oOverflow  = 1'b0;
    assign oUnderflow = 1'b0;
`endif

endmodule

// File: tb/tb_scfifo_param_withcount.sv
// Bench for scfifo_param_withcount: a standard-read and an FWFT instance
// share one stimulus stream and are compared against a queue-based model.
module tb_scfifo_param_withcount;

    localparam int DW    = 40;
    localparam int DEPTH = 64;
    localparam int AF    = 60;
    localparam int AE    = 4;
    localparam int CW    = 7;

`ifdef SCFIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          iClock = 1'b0;
    logic          iReset;
    logic [DW-1:0] iPushData;
    logic          iPushEnable;
    logic          iPopEnable;

    logic          sFull, sAF, sEmpty, sAE, sOvf, sUnf;
    logic [DW-1:0] sData;
    logic [CW-1:0] sCount;
    logic          fFull, fAF, fEmpty, fAE, fOvf, fUnf;
    logic [DW-1:0] fData;
    logic [CW-1:0] fCount;

    int nChecks = 0;
    int nErrors = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] mStd;
    logic [DW-1:0] mFw;
    logic          mOvf;
    logic          mUnf;

    always #5 iClock = ~iClock;

    scfifo_param_withcount #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF),
                             .AE_LEVEL(AE), .FWFT(0)) u_std (
        .iClock(iClock), .iReset(iReset), .iPushData(iPushData),
        .iPushEnable(iPushEnable), .oIsFull(sFull), .oAlmostFull(sAF),
        .oPopData(sData), .iPopEnable(iPopEnable), .oIsEmpty(sEmpty),
        .oAlmostEmpty(sAE), .oDataCount(sCount), .oOverflow(sOvf),
        .oUnderflow(sUnf)
    );

    scfifo_param_withcount #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF),
                             .AE_LEVEL(AE), .FWFT(1)) u_fwft (
        .iClock(iClock), .iReset(iReset), .iPushData(iPushData),
        .iPushEnable(iPushEnable), .oIsFull(fFull), .oAlmostFull(fAF),
        .oPopData(fData), .iPopEnable(iPopEnable), .oIsEmpty(fEmpty),
        .oAlmostEmpty(fAE), .oDataCount(fCount), .oOverflow(fOvf),
        .oUnderflow(fUnf)
    );

    function automatic logic [DW-1:0] rnd();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string ph);
        int n;
        n = q.size();
        chk({ph, " std.count"}, 64'(sCount), 64'(n));
        chk({ph, " std.empty"}, 64'(sEmpty), 64'(n == 0));
        chk({ph, " std.full"},  64'(sFull),  64'(n == DEPTH));
        chk({ph, " std.af"},    64'(sAF),    64'(n >= AF));
        chk({ph, " std.ae"},    64'(sAE),    64'(n <= AE));
        chk({ph, " std.data"},  64'(sData),  64'(mStd));
        chk({ph, " std.ovf"},   64'(sOvf),   64'(mOvf));
        chk({ph, " std.unf"},   64'(sUnf),   64'(mUnf));
        chk({ph, " fw.count"},  64'(fCount), 64'(n));
        chk({ph, " fw.empty"},  64'(fEmpty), 64'(n == 0));
        chk({ph, " fw.full"},   64'(fFull),  64'(n == DEPTH));
        chk({ph, " fw.af"},     64'(fAF),    64'(n >= AF));
        chk({ph, " fw.ae"},     64'(fAE),    64'(n <= AE));
        chk({ph, " fw.data"},   64'(fData),  64'(mFw));
        chk({ph, " fw.ovf"},    64'(fOvf),   64'(mOvf));
        chk({ph, " fw.unf"},    64'(fUnf),   64'(mUnf));
    endtask

    task automatic modelReset();
        q.delete();
        mStd = '0;
        mFw  = '0;
        mOvf = 1'b0;
        mUnf = 1'b0;
    endtask

    // One clock of stimulus, model update at the edge, check 1 time unit later.
    task automatic step(input string ph, input logic push, input logic [DW-1:0] d,
                        input logic pop);
        bit pa, pp;
        iPushEnable = push;
        iPushData   = d;
        iPopEnable  = pop;
        @(posedge iClock);
        pa = push && (q.size() < DEPTH);
        pp = pop && (q.size() > 0);
        if (ERR_EN && push && (q.size() == DEPTH)) mOvf = 1'b1;
        if (ERR_EN && pop && (q.size() == 0)) mUnf = 1'b1;
        if (pp) mStd = q.pop_front();
        if (pa) q.push_back(d);
        if (q.size() > 0) mFw = q[0];
        #1;
        checkAll(ph);
        iPushEnable = 1'b0;
        iPopEnable  = 1'b0;
    endtask

    initial begin
        iReset      = 1'b1;
        iPushEnable = 1'b0;
        iPopEnable  = 1'b0;
        iPushData   = '0;
        modelReset();
        @(posedge iClock);
        @(posedge iClock);
        #1;
        checkAll("reset");
        iReset = 1'b0;

        // Fill 0..63, then one push too many.
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, DW'(i), 1'b0);
        step("push_full", 1'b1, rnd(), 1'b0);

        // Drain all, then one pop too many.
        for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, '0, 1'b1);
        step("pop_empty", 1'b0, '0, 1'b1);

        // Steady push+pop at count 30, pointers wrap several times.
        for (int i = 0; i < 30; i++) step("to30", 1'b1, rnd(), 1'b0);
        for (int i = 0; i < 100; i++) step("pp30", 1'b1, rnd(), 1'b1);

        // Push+pop while full, then push+pop while empty.
        while (q.size() < DEPTH) step("to_full", 1'b1, rnd(), 1'b0);
        step("pp_full", 1'b1, rnd(), 1'b1);
        while (q.size() > 0) step("to_empty", 1'b0, '0, 1'b1);
        step("pp_empty", 1'b1, rnd(), 1'b1);
        step("pop_one", 1'b0, '0, 1'b1);

        // FWFT fall-through of 0xA5 and back-to-back pops.
        step("a5", 1'b1, DW'(40'hA5), 1'b0);
        step("w2", 1'b1, rnd(), 1'b0);
        step("w3", 1'b1, rnd(), 1'b0);
        for (int i = 0; i < 3; i++) step("b2b", 1'b0, '0, 1'b1);

        // Asynchronous reset mid-burst at count 17.
        for (int i = 0; i < 17; i++) step("to17", 1'b1, rnd(), 1'b0);
        #2;
        iReset = 1'b1;
        #1;
        modelReset();
        checkAll("areset");
        @(posedge iClock);
        #1;
        iReset = 1'b0;
        checkAll("areset_hold");

        // Fresh random traffic: fill-biased, then drain-biased.
        for (int i = 0; i < 300; i++) begin
            logic pu, po;
            pu = ($urandom_range(0, 99) < ((i < 150) ? 70 : 30));
            po = ($urandom_range(0, 99) < ((i < 150) ? 30 : 70));
            step("rand", pu, rnd(), po);
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
